// File: rtl/op_build_sequencer.sv
// op_build_sequencer: walks the op builder register stage through one G-code
// line at a time. Tokens from the parser arrive one per cycle and are turned
// into builder strobes. The seen-mask catches repeated fields and reserved
// tokens. The finished op is handed to motion with op_valid/op_ready.
//
// Optional feature: define OP_SEQ_MODAL_CMD_EN to let a line that has
// arguments but no command reuse the last G00-G03 command.
//
// Widths normally come from common.svh. The fallbacks below keep this file
// self-contained when it is built on its own.

`ifndef OP_CMD_BITS
`define OP_CMD_BITS 8
`endif
`ifndef OP_ARG_BITS
`define OP_ARG_BITS 16
`endif
`ifndef OP_FLAGS_BITS
`define OP_FLAGS_BITS 4
`endif

module op_build_sequencer (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_en,
  input  logic                      tok_valid,
  output logic                      tok_ready,
  input  logic [2:0]                tok_type,
  input  logic [`OP_ARG_BITS-1:0]   tok_value,
  output logic                      b_zero,
  output logic [`OP_CMD_BITS-1:0]   b_cmd,
  output logic [`OP_ARG_BITS-1:0]   b_arg,
  output logic [`OP_FLAGS_BITS-1:0] b_flags,
  output logic                      b_set_cmd,
  output logic                      b_set_arg_1,
  output logic                      b_set_arg_2,
  output logic                      b_set_arg_3,
  output logic                      b_set_arg_4,
  output logic                      b_set_flags,
  output logic                      op_valid,
  input  logic                      op_ready,
  output logic                      err,
  output logic [7:0]                err_cnt
);

  localparam logic [2:0] TOK_CMD   = 3'd0;
  localparam logic [2:0] TOK_X     = 3'd1;
  localparam logic [2:0] TOK_Y     = 3'd2;
  localparam logic [2:0] TOK_I     = 3'd3;
  localparam logic [2:0] TOK_J     = 3'd4;
  localparam logic [2:0] TOK_FLAGS = 3'd5;
  localparam logic [2:0] TOK_EOL   = 3'd6;
  localparam logic [2:0] TOK_RSVD  = 3'd7;

  localparam logic [`OP_CMD_BITS-1:0] CMD_G02 = `OP_CMD_BITS'(2);
  localparam logic [`OP_CMD_BITS-1:0] CMD_G03 = `OP_CMD_BITS'(3);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_COLLECT,
    ST_EMIT,
    ST_DISCARD
  } state_t;

  state_t                  state;
  logic [5:0]              seen_mask;
  logic [`OP_CMD_BITS-1:0] line_cmd;

  logic       accept;
  logic       in_collect;
  logic       is_eol;
  logic       is_rsvd;
  logic [5:0] field_bit;
  logic       dup_field;
  logic       has_ij;
  logic       cmd_ok;
  logic       fill_cmd;
  logic       ij_bad;
  logic       field_ok;
  logic       eol_good;
  logic       eol_bad;
  logic       tok_bad;
  logic [`OP_CMD_BITS-1:0] eff_cmd;

  assign tok_ready  = clk_en && ((state == ST_COLLECT) || (state == ST_DISCARD));
  assign accept     = tok_valid && tok_ready;
  assign in_collect = accept && (state == ST_COLLECT);
  assign is_eol     = (tok_type == TOK_EOL);
  assign is_rsvd    = (tok_type == TOK_RSVD);
  assign field_bit  = (tok_type <= TOK_FLAGS) ? (6'b000001 << tok_type) : 6'b000000;
  assign dup_field  = |(seen_mask & field_bit);
  assign has_ij     = seen_mask[TOK_I] || seen_mask[TOK_J];

`ifdef OP_SEQ_MODAL_CMD_EN
  logic [`OP_CMD_BITS-1:0] modal_cmd;
  logic                    modal_load;
  localparam logic [`OP_ARG_BITS-1:0] MODAL_MAX = `OP_ARG_BITS'(3);

  assign fill_cmd   = !seen_mask[TOK_CMD] && (|seen_mask[4:1]);
  assign cmd_ok     = seen_mask[TOK_CMD] || fill_cmd;
  assign eff_cmd    = seen_mask[TOK_CMD] ? line_cmd : modal_cmd;
  assign modal_load = field_ok && (tok_type == TOK_CMD) && (tok_value <= MODAL_MAX);
  assign b_cmd      = (fill_cmd && is_eol) ? modal_cmd : tok_value[`OP_CMD_BITS-1:0];

  // Remember the last motion command (G00-G03) across lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      modal_cmd <= '0;
    end else if (clk_en && modal_load) begin
      modal_cmd <= tok_value[`OP_CMD_BITS-1:0];
    end
  end
`else
  assign fill_cmd = 1'b0;
  assign cmd_ok   = seen_mask[TOK_CMD];
  assign eff_cmd  = line_cmd;
  assign b_cmd    = tok_value[`OP_CMD_BITS-1:0];
`endif

  assign ij_bad   = has_ij && !((eff_cmd == CMD_G02) || (eff_cmd == CMD_G03));
  assign field_ok = in_collect && !is_eol && !is_rsvd && !dup_field;
  assign tok_bad  = in_collect && !is_eol && (is_rsvd || dup_field);
  assign eol_good = in_collect && is_eol && cmd_ok && !ij_bad;
  assign eol_bad  = in_collect && is_eol && !(cmd_ok && !ij_bad);
  assign err      = tok_bad || eol_bad;

  assign b_zero      = clk_en && (state == ST_CLEAR);
  assign b_arg       = tok_value;
  assign b_flags     = tok_value[`OP_FLAGS_BITS-1:0];
  assign b_set_cmd   = (field_ok && (tok_type == TOK_CMD)) || (eol_good && fill_cmd);
  assign b_set_arg_1 = field_ok && (tok_type == TOK_X);
  assign b_set_arg_2 = field_ok && (tok_type == TOK_Y);
  assign b_set_arg_3 = field_ok && (tok_type == TOK_I);
  assign b_set_arg_4 = field_ok && (tok_type == TOK_J);
  assign b_set_flags = field_ok && (tok_type == TOK_FLAGS);

  // Line sequencing FSM, per-line field tracking and the rejected-line counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_CLEAR;
      seen_mask <= '0;
      line_cmd  <= '0;
      op_valid  <= 1'b0;
      err_cnt   <= '0;
    end else if (clk_en) begin
      if (err && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
      case (state)
        ST_CLEAR: begin
          seen_mask <= '0;
          line_cmd  <= '0;
          state     <= ST_COLLECT;
        end
        ST_COLLECT: begin
          if (field_ok) begin
            seen_mask <= seen_mask | field_bit;
            if (tok_type == TOK_CMD) begin
              line_cmd <= tok_value[`OP_CMD_BITS-1:0];
            end
          end
          if (eol_good) begin
            state    <= ST_EMIT;
            op_valid <= 1'b1;
          end else if (eol_bad) begin
            state <= ST_CLEAR;
          end else if (tok_bad) begin
            state <= ST_DISCARD;
          end
        end
        ST_EMIT: begin
          if (op_ready) begin
            state    <= ST_CLEAR;
            op_valid <= 1'b0;
          end
        end
        ST_DISCARD: begin
          if (accept && is_eol) begin
            state <= ST_CLEAR;
          end
        end
        default: begin
          state <= ST_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_op_build_sequencer.sv
// tb_op_build_sequencer: directed bench for op_build_sequencer. A small
// model of the op builder register stage sits beside the DUT and is driven by
// the DUT's strobes. The ops it captures are compared against hand-computed
// values.

`ifndef OP_CMD_BITS
`define OP_CMD_BITS 8
`endif
`ifndef OP_ARG_BITS
`define OP_ARG_BITS 16
`endif
`ifndef OP_FLAGS_BITS
`define OP_FLAGS_BITS 4
`endif

module tb_op_build_sequencer;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      clk_en;
  logic                      tok_valid;
  logic                      tok_ready;
  logic [2:0]                tok_type;
  logic [`OP_ARG_BITS-1:0]   tok_value;
  logic                      b_zero;
  logic [`OP_CMD_BITS-1:0]   b_cmd;
  logic [`OP_ARG_BITS-1:0]   b_arg;
  logic [`OP_FLAGS_BITS-1:0] b_flags;
  logic                      b_set_cmd;
  logic                      b_set_arg_1;
  logic                      b_set_arg_2;
  logic                      b_set_arg_3;
  logic                      b_set_arg_4;
  logic                      b_set_flags;
  logic                      op_valid;
  logic                      op_ready;
  logic                      err;
  logic [7:0]                err_cnt;

  logic [`OP_CMD_BITS-1:0]   m_cmd;
  logic [`OP_ARG_BITS-1:0]   m_x;
  logic [`OP_ARG_BITS-1:0]   m_y;
  logic [`OP_ARG_BITS-1:0]   m_i;
  logic [`OP_ARG_BITS-1:0]   m_j;
  logic [`OP_FLAGS_BITS-1:0] m_flags;

  int   checks   = 0;
  int   failures = 0;
  logic last_err;

  localparam logic [2:0] T_CMD = 3'd0, T_X = 3'd1, T_Y = 3'd2, T_I = 3'd3,
                         T_J = 3'd4, T_FLAGS = 3'd5, T_EOL = 3'd6, T_RSVD = 3'd7;

  op_build_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .tok_valid   (tok_valid),
    .tok_ready   (tok_ready),
    .tok_type    (tok_type),
    .tok_value   (tok_value),
    .b_zero      (b_zero),
    .b_cmd       (b_cmd),
    .b_arg       (b_arg),
    .b_flags     (b_flags),
    .b_set_cmd   (b_set_cmd),
    .b_set_arg_1 (b_set_arg_1),
    .b_set_arg_2 (b_set_arg_2),
    .b_set_arg_3 (b_set_arg_3),
    .b_set_arg_4 (b_set_arg_4),
    .b_set_flags (b_set_flags),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .err         (err),
    .err_cnt     (err_cnt)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Behavioural op builder: zero clears everything, strobes load fields.
  always @(posedge clk) begin
    if (b_zero) begin
      m_cmd <= '0; m_x <= '0; m_y <= '0; m_i <= '0; m_j <= '0; m_flags <= '0;
    end else begin
      if (b_set_cmd)   m_cmd   <= b_cmd;
      if (b_set_arg_1) m_x     <= b_arg;
      if (b_set_arg_2) m_y     <= b_arg;
      if (b_set_arg_3) m_i     <= b_arg;
      if (b_set_arg_4) m_j     <= b_arg;
      if (b_set_flags) m_flags <= b_flags;
    end
  end

  function automatic logic [127:0] pack_op(input logic [`OP_CMD_BITS-1:0] c,
                                           input logic [`OP_ARG_BITS-1:0] x,
                                           input logic [`OP_ARG_BITS-1:0] y,
                                           input logic [`OP_ARG_BITS-1:0] i,
                                           input logic [`OP_ARG_BITS-1:0] j,
                                           input logic [`OP_FLAGS_BITS-1:0] f);
    return 128'({c, x, y, i, j, f});
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOp(input string tag, input logic [127:0] exp);
    checkOutput(tag, pack_op(m_cmd, m_x, m_y, m_i, m_j, m_flags), exp);
  endtask

  task automatic waitCycle();
    @(negedge clk);
    #1;
  endtask

  // Present one token, wait (bounded) for acceptance, capture err in the accept cycle.
  task automatic applyStimulus(input logic [2:0] t, input logic [`OP_ARG_BITS-1:0] v);
    int n;
    n = 0;
    @(negedge clk);
    tok_valid = 1'b1;
    tok_type  = t;
    tok_value = v;
    #1;
    while (!tok_ready && n < 20) begin
      waitCycle();
      n++;
    end
    if (!tok_ready) begin
      checkOutput("tok_ready_timeout", 128'(tok_ready), 128'(1));
      tok_valid = 1'b0;
    end else begin
      last_err = err;
      @(posedge clk);
      #1;
      tok_valid = 1'b0;
    end
  endtask

  initial begin
    reset     = 1'b1;
    clk_en    = 1'b1;
    tok_valid = 1'b0;
    tok_type  = '0;
    tok_value = '0;
    op_ready  = 1'b1;
    last_err  = 1'b0;

    // Reset state
    repeat (2) waitCycle();
    checkOutput("rst_b_zero",   128'(b_zero),    128'(1));
    checkOutput("rst_op_valid", 128'(op_valid),  128'(0));
    checkOutput("rst_tok_ready",128'(tok_ready), 128'(0));
    checkOutput("rst_err",      128'(err),       128'(0));
    checkOutput("rst_err_cnt",  128'(err_cnt),   128'(0));
    reset = 1'b0;

    // Full G03 line with op_ready already high
    applyStimulus(T_CMD, 3);
    applyStimulus(T_X, 1);
    applyStimulus(T_Y, 2);
    applyStimulus(T_I, 3);
    applyStimulus(T_J, 4);
    applyStimulus(T_FLAGS, 3);
    applyStimulus(T_EOL, 0);
    waitCycle();
    checkOutput("l1_op_valid", 128'(op_valid), 128'(1));
    checkOp("l1_op", pack_op(3, 1, 2, 3, 4, 3));
    waitCycle();
    checkOutput("l1_valid_drop", 128'(op_valid), 128'(0));
    checkOutput("l1_b_zero", 128'(b_zero), 128'(1));
    waitCycle();
    checkOp("l1_cleared", pack_op(0, 0, 0, 0, 0, 0));

    // Back-pressure: op_ready low for 4 EMIT cycles
    op_ready = 1'b0;
    applyStimulus(T_CMD, 1);
    applyStimulus(T_X, 5);
    applyStimulus(T_EOL, 0);
    for (int k = 0; k < 4; k++) begin
      waitCycle();
      checkOutput("l2_hold_valid", 128'(op_valid), 128'(1));
      checkOutput("l2_hold_ready", 128'(tok_ready), 128'(0));
      checkOp("l2_op", pack_op(1, 5, 0, 0, 0, 0));
    end
    op_ready = 1'b1;
    waitCycle();
    checkOutput("l2_clear_ready", 128'(tok_ready), 128'(0));
    checkOutput("l2_clear_zero", 128'(b_zero), 128'(1));
    waitCycle();
    checkOutput("l2_ready_back", 128'(tok_ready), 128'(1));

    // Clock enable low freezes and gates strobes
    @(negedge clk);
    clk_en    = 1'b0;
    tok_valid = 1'b1;
    tok_type  = T_CMD;
    tok_value = 7;
    #1;
    checkOutput("ce_tok_ready", 128'(tok_ready), 128'(0));
    checkOutput("ce_set_cmd", 128'(b_set_cmd), 128'(0));
    @(posedge clk);
    #1;
    clk_en    = 1'b1;
    tok_valid = 1'b0;
    waitCycle();
    checkOutput("ce_state_held", 128'(tok_ready), 128'(1));

    // Duplicate X rejects the line
    applyStimulus(T_CMD, 0);
    applyStimulus(T_X, 1);
    checkOutput("dup_first_x_err", 128'(last_err), 128'(0));
    applyStimulus(T_X, 2);
    checkOutput("dup_err", 128'(last_err), 128'(1));
    applyStimulus(T_Y, 7);
    checkOutput("discard_y_err", 128'(last_err), 128'(0));
    applyStimulus(T_EOL, 0);
    checkOutput("discard_eol_err", 128'(last_err), 128'(0));
    waitCycle();
    checkOutput("dup_no_valid", 128'(op_valid), 128'(0));
    checkOutput("dup_b_zero", 128'(b_zero), 128'(1));
    checkOutput("dup_err_cnt", 128'(err_cnt), 128'(1));
    applyStimulus(T_CMD, 90);
    applyStimulus(T_EOL, 0);
    waitCycle();
    checkOutput("g90_valid", 128'(op_valid), 128'(1));
    checkOp("g90_op", pack_op(90, 0, 0, 0, 0, 0));

    // I on a G01 line is rejected at EOL
    applyStimulus(T_CMD, 1);
    applyStimulus(T_I, 4);
    checkOutput("ij_i_err", 128'(last_err), 128'(0));
    applyStimulus(T_EOL, 0);
    checkOutput("ij_eol_err", 128'(last_err), 128'(1));
    waitCycle();
    checkOutput("ij_no_valid", 128'(op_valid), 128'(0));
    checkOutput("ij_err_cnt", 128'(err_cnt), 128'(2));

    // Line without a command after a G02 line
    applyStimulus(T_CMD, 2);
    applyStimulus(T_X, 1);
    applyStimulus(T_EOL, 0);
    waitCycle();
    checkOutput("g02_valid", 128'(op_valid), 128'(1));
    applyStimulus(T_X, 9);
    applyStimulus(T_EOL, 0);
`ifdef OP_SEQ_MODAL_CMD_EN
    checkOutput("modal_eol_err", 128'(last_err), 128'(0));
    waitCycle();
    checkOutput("modal_valid", 128'(op_valid), 128'(1));
    checkOp("modal_op", pack_op(2, 9, 0, 0, 0, 0));
    checkOutput("modal_err_cnt", 128'(err_cnt), 128'(2));
`else
    checkOutput("nocmd_eol_err", 128'(last_err), 128'(1));
    waitCycle();
    checkOutput("nocmd_no_valid", 128'(op_valid), 128'(0));
    checkOutput("nocmd_err_cnt", 128'(err_cnt), 128'(3));
`endif

    // Error counter saturation
    for (int n = 0; n < 260; n++) begin
      applyStimulus(T_RSVD, 0);
      applyStimulus(T_EOL, 0);
    end
    waitCycle();
    checkOutput("err_cnt_sat", 128'(err_cnt), 128'(255));

    // Reset mid-line aborts it
    applyStimulus(T_CMD, 1);
    applyStimulus(T_X, 5);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    waitCycle();
    checkOutput("mid_rst_b_zero", 128'(b_zero), 128'(1));
    checkOutput("mid_rst_err_cnt", 128'(err_cnt), 128'(0));
    checkOutput("mid_rst_valid", 128'(op_valid), 128'(0));
    waitCycle();
    checkOutput("mid_rst_valid2", 128'(op_valid), 128'(0));
    applyStimulus(T_CMD, 0);
    applyStimulus(T_Y, 3);
    applyStimulus(T_EOL, 0);
    waitCycle();
    checkOutput("post_rst_valid", 128'(op_valid), 128'(1));
    checkOp("post_rst_op", pack_op(0, 0, 3, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
